menu_app_selector: RTL and testbench

//  Parametrised menu/app state machine for the top-level integration. Takes raw

---
 rtl/menu_app_selector.sv | 186 ++++++++++++++++++
 tb/tb_menu_app_selector.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/menu_app_selector.sv
// Menu/app selector: synchronises four push-buttons, qualifies each press on a
// sustained release, and steps a cursor / enters / leaves apps on those events.

module menu_btn_qual #(
   parameter int unsigned RELEASE_CYCLES = 6_250_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic b_i,
   output logic q_o
);

   localparam int unsigned CNT_W = $clog2(RELEASE_CYCLES);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ARMED = 1'b1
   } btn_state_e;

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             q_q, q_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         q_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         q_q     <= q_d;
      end
   end

   // A high level re-arms and restarts the release count; the event fires on the last low cycle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      q_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (b_i) begin
               state_d = S_ARMED;
               count_d = '0;
            end
         end
         S_ARMED: begin
            if (b_i) begin
               count_d = '0;
            end else if (count_q == CNT_W'(RELEASE_CYCLES - 1)) begin
               q_d     = 1'b1;
               state_d = S_IDLE;
               count_d = '0;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase
   end

   assign q_o = q_q;

endmodule

module menu_app_selector #(
   parameter int unsigned NUM_APPS       = 8,
   parameter int unsigned RELEASE_CYCLES = 6_250_000,
   parameter bit          WRAP           = 1'b1,
   parameter int unsigned STATE_W        = $clog2(NUM_APPS + 1),
   parameter int unsigned CUR_W          = $clog2(NUM_APPS)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               btn_enter,
   input  logic               btn_back,
   input  logic               btn_prev,
   input  logic               btn_next,
   output logic [STATE_W-1:0] machine_state,
   output logic [CUR_W-1:0]   menu_cursor,
   output logic               in_app,
   output logic               enter_pulse,
   output logic               exit_pulse
);

   localparam int unsigned NUM_BTN = 4;
   localparam int unsigned I_ENTER = 0;
   localparam int unsigned I_BACK  = 1;
   localparam int unsigned I_PREV  = 2;
   localparam int unsigned I_NEXT  = 3;

   logic [NUM_BTN-1:0] sync1_q, sync2_q;
   logic [NUM_BTN-1:0] q_evt;

   logic [STATE_W-1:0] state_q, state_d;
   logic [CUR_W-1:0]   cursor_q, cursor_d;
   logic               in_app_q, in_app_d;
   logic               enter_pulse_q, enter_pulse_d;
   logic               exit_pulse_q, exit_pulse_d;

   logic win_enter, win_back, win_next, win_prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {btn_next, btn_prev, btn_back, btn_enter};
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      menu_btn_qual #(
         .RELEASE_CYCLES(RELEASE_CYCLES)
      ) u_qual (
         .clock  (clock),
         .reset_n(reset_n),
         .b_i    (sync2_q[i]),
         .q_o    (q_evt[i])
      );
   end

   // Fixed priority enter > back > next > prev; losers are dropped.
   assign win_enter = q_evt[I_ENTER];
   assign win_back  = q_evt[I_BACK] & ~q_evt[I_ENTER];
   assign win_next  = q_evt[I_NEXT] & ~q_evt[I_ENTER] & ~q_evt[I_BACK];
   assign win_prev  = q_evt[I_PREV] & ~q_evt[I_ENTER] & ~q_evt[I_BACK] & ~q_evt[I_NEXT];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= '0;
         cursor_q      <= '0;
         in_app_q      <= 1'b0;
         enter_pulse_q <= 1'b0;
         exit_pulse_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cursor_q      <= cursor_d;
         in_app_q      <= in_app_d;
         enter_pulse_q <= enter_pulse_d;
         exit_pulse_q  <= exit_pulse_d;
      end
   end

   // Menu moves the cursor or enters; inside an app only back is honoured.
   always_comb begin
      state_d       = state_q;
      cursor_d      = cursor_q;
      enter_pulse_d = 1'b0;
      exit_pulse_d  = 1'b0;
      if (!in_app_q) begin
         if (win_enter) begin
            state_d       = STATE_W'(cursor_q) + STATE_W'(1);
            enter_pulse_d = 1'b1;
         end else if (win_next) begin
            if (cursor_q == CUR_W'(NUM_APPS - 1)) begin
               cursor_d = WRAP ? '0 : cursor_q;
            end else begin
               cursor_d = cursor_q + CUR_W'(1);
            end
         end else if (win_prev) begin
            if (cursor_q == '0) begin
               cursor_d = WRAP ? CUR_W'(NUM_APPS - 1) : cursor_q;
            end else begin
               cursor_d = cursor_q - CUR_W'(1);
            end
         end
      end else if (win_back) begin
         state_d      = '0;
         exit_pulse_d = 1'b1;
      end
      in_app_d = (state_d != '0);
   end

   assign machine_state = state_q;
   assign menu_cursor   = cursor_q;
   assign in_app        = in_app_q;
   assign enter_pulse   = enter_pulse_q;
   assign exit_pulse    = exit_pulse_q;

endmodule

// File: tb/tb_menu_app_selector.sv
// Directed bench for menu_app_selector: two instances (wrapping and saturating cursor)
// share the same button stimulus.

module tb_menu_app_selector;

   localparam int unsigned NUM_APPS = 5;
   localparam int unsigned RC       = 4;
   localparam int unsigned STATE_W  = $clog2(NUM_APPS + 1);
   localparam int unsigned CUR_W    = $clog2(NUM_APPS);

   localparam logic [3:0] M_ENTER = 4'b0001;
   localparam logic [3:0] M_BACK  = 4'b0010;
   localparam logic [3:0] M_PREV  = 4'b0100;
   localparam logic [3:0] M_NEXT  = 4'b1000;

   logic clock;
   logic reset_n;
   logic btn_enter, btn_back, btn_prev, btn_next;

   logic [STATE_W-1:0] ms0, ms1;
   logic [CUR_W-1:0]   cur0, cur1;
   logic               app0, app1, en0, en1, ex0, ex1;

   int checks = 0;
   int errors = 0;

   menu_app_selector #(.NUM_APPS(NUM_APPS), .RELEASE_CYCLES(RC), .WRAP(1'b1)) u_wrap (
      .clock(clock), .reset_n(reset_n),
      .btn_enter(btn_enter), .btn_back(btn_back), .btn_prev(btn_prev), .btn_next(btn_next),
      .machine_state(ms0), .menu_cursor(cur0), .in_app(app0),
      .enter_pulse(en0), .exit_pulse(ex0)
   );

   menu_app_selector #(.NUM_APPS(NUM_APPS), .RELEASE_CYCLES(RC), .WRAP(1'b0)) u_sat (
      .clock(clock), .reset_n(reset_n),
      .btn_enter(btn_enter), .btn_back(btn_back), .btn_prev(btn_prev), .btn_next(btn_next),
      .machine_state(ms1), .menu_cursor(cur1), .in_app(app1),
      .enter_pulse(en1), .exit_pulse(ex1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_btns(input logic [3:0] m);
      {btn_next, btn_prev, btn_back, btn_enter} = m;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
   endtask

   // Hold 3 cycles, release, and stop on the cycle the top-level update is visible.
   task automatic press(input logic [3:0] m);
      set_btns(m);
      cyc(3);
      set_btns(4'b0000);
      cyc(7);
   endtask

   initial begin
      reset_n = 1'b0;
      set_btns(4'b0000);

      // 1: reset values and release-to-entry latency
      cyc(3);
      chk("rst_state", 32'(ms0), 0);
      chk("rst_cursor", 32'(cur0), 0);
      chk("rst_in_app", 32'(app0), 0);
      chk("rst_pulses", 32'({en0, ex0}), 0);
      reset_n = 1'b1;
      cyc(2);
      chk("post_rst_state", 32'(ms0), 0);
      set_btns(M_ENTER);
      cyc(3);
      set_btns(4'b0000);
      cyc(6);
      chk("t1_state_before", 32'(ms0), 0);
      chk("t1_pulse_before", 32'(en0), 0);
      cyc(1);
      chk("t1_state", 32'(ms0), 1);
      chk("t1_enter_pulse", 32'(en0), 1);
      chk("t1_in_app", 32'(app0), 1);
      cyc(1);
      chk("t1_pulse_clear", 32'(en0), 0);
      chk("t1_state_hold", 32'(ms0), 1);

      // 2: cursor wrap vs saturate
      do_reset();
      for (int i = 0; i < 5; i++) begin
         press(M_NEXT);
         chk("t2_wrap_next", 32'(cur0), 32'((i + 1) % 5));
         chk("t2_sat_next", 32'(cur1), (i < 4) ? 32'(i + 1) : 32'd4);
      end
      do_reset();
      press(M_PREV);
      chk("t2_wrap_prev0", 32'(cur0), 4);
      chk("t2_sat_prev0", 32'(cur1), 0);

      // 3: bounce restarts the release count
      do_reset();
      set_btns(M_NEXT);
      cyc(3);
      set_btns(4'b0000);
      cyc(2);
      set_btns(M_NEXT);
      cyc(1);
      set_btns(4'b0000);
      cyc(6);
      chk("t3_before", 32'(cur0), 0);
      cyc(1);
      chk("t3_once", 32'(cur0), 1);
      cyc(12);
      chk("t3_no_extra", 32'(cur0), 1);

      // 4: enter at cursor 3, ignored keys in app, back restores menu
      do_reset();
      press(M_NEXT);
      press(M_NEXT);
      press(M_NEXT);
      chk("t4_cursor3", 32'(cur0), 3);
      press(M_ENTER);
      chk("t4_state", 32'(ms0), 4);
      chk("t4_enter_pulse", 32'(en0), 1);
      chk("t4_in_app", 32'(app0), 1);
      cyc(1);
      chk("t4_pulse_clear", 32'(en0), 0);
      press(M_PREV);
      chk("t4_prev_state", 32'(ms0), 4);
      chk("t4_prev_cursor", 32'(cur0), 3);
      press(M_NEXT);
      chk("t4_next_cursor", 32'(cur0), 3);
      press(M_ENTER);
      chk("t4_reenter_state", 32'(ms0), 4);
      chk("t4_reenter_pulse", 32'(en0), 0);
      press(M_BACK);
      chk("t4_back_state", 32'(ms0), 0);
      chk("t4_exit_pulse", 32'(ex0), 1);
      chk("t4_back_cursor", 32'(cur0), 3);
      chk("t4_back_in_app", 32'(app0), 0);
      cyc(1);
      chk("t4_exit_clear", 32'(ex0), 0);

      // 5: simultaneous enter+next, enter wins
      do_reset();
      press(M_NEXT);
      press(M_NEXT);
      press(M_ENTER | M_NEXT);
      chk("t5_state", 32'(ms0), 3);
      chk("t5_cursor", 32'(cur0), 2);
      chk("t5_pulse", 32'(en0), 1);

      // 6: reset mid-count produces no event
      do_reset();
      set_btns(M_ENTER);
      cyc(3);
      set_btns(4'b0000);
      cyc(4);
      reset_n = 1'b0;
      cyc(2);
      chk("t6_in_reset", 32'(ms0), 0);
      reset_n = 1'b1;
      cyc(15);
      chk("t6_no_event_state", 32'(ms0), 0);
      chk("t6_no_event_app", 32'(app0), 0);
      press(M_ENTER);
      chk("t6_new_press", 32'(ms0), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
